up_down_count: RTL and testbench
================================

UP_DOWN_COUNT -- requirements
Module: up_down_count

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: Clk  input  1  clock; every register updates on its rising edge.
REQ-003 Port: Reset  input  1  synchronous active-high reset, sampled on Clk rising edge.
REQ-004 Port: Enable  input  1  count enable; high = both counters step this cycle.
REQ-005 Port: Swap  input  1  exchange request; acted on at its rising edge only.
REQ-006 Port: UpCountS  output  4  incrementing counter value, driven directly from a register.
REQ-007 Port: DownCountS  output  4  decrementing counter value, driven directly from a register.
REQ-008 Port, present only with UPDOWNCOUNT_TC_EN: UpTc  output  1  high while UpCountS == 4'hF.
REQ-009 Port, present only with UPDOWNCOUNT_TC_EN: DownTc  output  1  high while DownCountS == 4'h0.

Function
REQ-010 SHALL register Swap into Swap_q every cycle; swap event = Swap & ~Swap_q, evaluated at the same clock edge.
REQ-011 On a swap event, SHALL exchange values at that edge: UpCountS <= old DownCountS, DownCountS <= old UpCountS.
REQ-012 A swap event SHALL take priority over Enable; no counting occurs in that cycle.
REQ-013 Swap held high for multiple cycles SHALL produce exactly one exchange; a new exchange requires Swap to go low for at least one sampled edge.
REQ-014 Without a swap event and with Enable=1, SHALL set UpCountS <= UpCountS+1 and DownCountS <= DownCountS-1, modulo 16.
REQ-015 Wrap: UpCountS 4'hF -> 4'h0; DownCountS 4'h0 -> 4'hF; no saturation, no stall.
REQ-016 With Enable=0 and no swap event, both counters SHALL hold.
REQ-017 Counter update latency SHALL be one clock: inputs sampled at edge N are visible on the outputs after edge N.
REQ-018 Inputs SHALL be treated as synchronous to Clk; no internal synchronizers.

Reset
REQ-019 Reset=1 at a Clk edge SHALL force UpCountS=4'h0, DownCountS=4'hF and Swap_q=0, overriding Enable and Swap.
REQ-020 Reset asserted mid-count or during a held Swap SHALL abort the operation; after release, a still-high Swap SHALL count as a new rising edge on the first edge after release.
REQ-021 Before the first reset, outputs are undefined; no reliance on initial values.

Configuration
REQ-022 Macro UPDOWNCOUNT_TC_EN defined: UpTc/DownTc ports exist as combinational decodes of the registered counters (UpTc=1 after reset is false, DownTc=0 after reset is false; both 0 after reset).
REQ-023 Macro UPDOWNCOUNT_TC_EN undefined: UpTc/DownTc ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Reset for 2 cycles, Enable=0, Swap=0 -> UpCountS=0, DownCountS=15, held for 5 further cycles.
REQ-025 Enable=1 for 3 cycles from reset -> Up/Down = 1/14, 2/13, 3/12; Enable=0 for 1 cycle -> holds 3/12; Enable=1 again -> 4/11.
REQ-026 Enable=1 for 16 cycles from reset -> the 16th edge wraps to Up=0, Down=15; with UPDOWNCOUNT_TC_EN, UpTc=1 after edge 15 (Up=15, Down=0, DownTc=1 simultaneously).
REQ-027 At Up=3, Down=12, Enable=1, Swap high for 1 cycle -> Up=12, Down=3 (no count); next edge -> Up=13, Down=2.
REQ-028 Swap held high for 4 cycles with Enable=1 from Up=2, Down=13 -> exactly one exchange (13/2), then counting 14/1, 15/0, 0/15.
REQ-029 Reset asserted while Swap=1 and Enable=1 -> 0/15 during reset; Swap still high on the first edge after release -> swap event, giving Up=15, Down=0.

Source files
------------

// File: rtl/up_down_count.sv
// ----------------------------------------------------------------------------
// up_down_count
// Pair of 4-bit counters stepping in opposite directions. A rising edge on
// Swap exchanges the two counter values instead of counting that cycle.
//
// Ports:
//   Clk        in   1  clock, all registers update on its rising edge
//   Reset      in   1  synchronous active-high reset
//   Enable     in   1  count enable (up counter +1, down counter -1)
//   Swap       in   1  exchange request, acted on at its rising edge only
//   UpCountS   out  4  incrementing counter (registered)
//   DownCountS out  4  decrementing counter (registered)
//   UpTc       out  1  high while UpCountS == 4'hF   (UPDOWNCOUNT_TC_EN only)
//   DownTc     out  1  high while DownCountS == 4'h0 (UPDOWNCOUNT_TC_EN only)
//
// Build option:
//   UPDOWNCOUNT_TC_EN  when defined, adds the UpTc/DownTc terminal-count ports.
// ----------------------------------------------------------------------------
module up_down_count (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Swap,
    output logic [3:0] UpCountS,
    output logic [3:0] DownCountS
`ifdef UPDOWNCOUNT_TC_EN
    ,
    output logic       UpTc,
    output logic       DownTc
`endif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] UP_RST   = CNT_W'(0);
    localparam logic [CNT_W-1:0] DOWN_RST = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_up_cnt;
    logic [CNT_W-1:0] r_down_cnt;
    logic             r_swap_q;
    logic             w_swap_evt;

    // Swap acts only on a low-to-high transition seen between two edges.
    assign w_swap_evt = Swap & ~r_swap_q;

    // Counter and swap-history registers; exchange has priority over counting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_up_cnt   <= UP_RST;
            r_down_cnt <= DOWN_RST;
            r_swap_q   <= 1'b0;
        end else begin
            r_swap_q <= Swap;
            if (w_swap_evt) begin
                r_up_cnt   <= r_down_cnt;
                r_down_cnt <= r_up_cnt;
            end else if (Enable) begin
                r_up_cnt   <= r_up_cnt + CNT_W'(1);
                r_down_cnt <= r_down_cnt - CNT_W'(1);
            end
        end
    end

    assign UpCountS   = r_up_cnt;
    assign DownCountS = r_down_cnt;

`ifdef UPDOWNCOUNT_TC_EN
    // Terminal-count decodes of the registered counters.
    assign UpTc   = (r_up_cnt == {CNT_W{1'b1}});
    assign DownTc = (r_down_cnt == CNT_W'(0));
`endif

endmodule

// File: tb/tb_up_down_count.sv
module tb_up_down_count;

    logic       Clk;
    logic       Reset;
    logic       Enable;
    logic       Swap;
    logic [3:0] UpCountS;
    logic [3:0] DownCountS;
`ifdef UPDOWNCOUNT_TC_EN
    logic       UpTc;
    logic       DownTc;
`endif

    int n_checks;
    int n_fail;

    up_down_count dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .Swap       (Swap),
        .UpCountS   (UpCountS),
        .DownCountS (DownCountS)
`ifdef UPDOWNCOUNT_TC_EN
        ,
        .UpTc       (UpTc),
        .DownTc     (DownTc)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int up, input int down);
        check_eq({tag, ".up"}, int'(UpCountS), up);
        check_eq({tag, ".down"}, int'(DownCountS), down);
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        Enable = 1'b0;
        Swap   = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Enable   = 1'b0;
        Swap     = 1'b0;

        // Reset state and hold with Enable=0.
        do_reset();
        check_cnt("rst", 0, 15);
`ifdef UPDOWNCOUNT_TC_EN
        check_eq("rst.uptc", int'(UpTc), 0);
        check_eq("rst.downtc", int'(DownTc), 0);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            check_cnt("idle_hold", 0, 15);
        end

        // Basic counting, hold, resume.
        Enable = 1'b1;
        step(); check_cnt("cnt1", 1, 14);
        step(); check_cnt("cnt2", 2, 13);
        step(); check_cnt("cnt3", 3, 12);
        Enable = 1'b0;
        step(); check_cnt("hold", 3, 12);
        Enable = 1'b1;
        step(); check_cnt("cnt4", 4, 11);

        // Full 16-cycle wrap with terminal counts.
        do_reset();
        Enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_cnt("wrap", i % 16, (15 - i + 16) % 16);
`ifdef UPDOWNCOUNT_TC_EN
            check_eq("wrap.uptc", int'(UpTc), (i == 15) ? 1 : 0);
            check_eq("wrap.downtc", int'(DownTc), (i == 15) ? 1 : 0);
`endif
        end

        // Single-cycle swap beats Enable, then counting resumes.
        do_reset();
        Enable = 1'b1;
        step(); step(); step();
        check_cnt("pre_swap", 3, 12);
        Swap = 1'b1;
        step(); check_cnt("swap1", 12, 3);
        Swap = 1'b0;
        step(); check_cnt("post_swap", 13, 2);

        // Swap held for 4 cycles gives one exchange only.
        do_reset();
        Enable = 1'b1;
        step(); step();
        check_cnt("pre_hold", 2, 13);
        Swap = 1'b1;
        step(); check_cnt("hold_swap1", 13, 2);
        step(); check_cnt("hold_swap2", 14, 1);
        step(); check_cnt("hold_swap3", 15, 0);
        step(); check_cnt("hold_swap4", 0, 15);
        Swap = 1'b0;
        step(); check_cnt("hold_rel", 1, 14);
        // A fresh rising edge after a low sample exchanges again.
        Swap = 1'b1;
        step(); check_cnt("reswap", 14, 1);
        Swap = 1'b0;
        Enable = 1'b0;
        step(); check_cnt("reswap_hold", 14, 1);

        // Reset during held Swap; Swap still high after release is a new edge.
        Enable = 1'b1;
        Swap   = 1'b1;
        step(); check_cnt("pre_rst_swap", 1, 14);
        Reset = 1'b1;
        step(); check_cnt("rst_swap1", 0, 15);
        step(); check_cnt("rst_swap2", 0, 15);
        Reset = 1'b0;
        step(); check_cnt("rel_swap", 15, 0);
        step(); check_cnt("rel_count", 0, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
